msk_mixcol_seq: RTL and testbench
=================================

Name: msk_mixcol_seq

Overview:
- Sequential controller that time-shares one masked combined MixColumns column unit across the 4 columns of a masked 128-bit AES state.
- Accepts a full shared state plus a direction flag over a valid/ready handshake. Feeds one column per cycle through the unit and collects results in a state register. Presents the processed state over a second valid/ready handshake.
- Sits between the round-state register and AddRoundKey in the 32-bit-datapath masked AES core. Shares are treated linearly only: no randomness is consumed.

Parameters:
- d, 2, number of shares (masking order + 1); every byte is an 8*d-bit sharing.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input state valid.
- in_ready  output  1  block can accept a state this cycle.
- in_inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept.
- in_state  input  128*d  shared state; byte i at [8*d*i +: 8*d]; column c = bytes 4c..4c+3, byte 4c is row 0.
- out_valid  output  1  processed state valid.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  128*d  processed shared state, same layout as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (rst_n low, asynchronous) forces IDLE, col_cnt=0, inv_q=0, state register=0. Outputs after reset: out_valid=0, busy=0, in_ready=1, out_state=0.
- IDLE:
  - in_ready=1.
  - On in_valid: load in_state into the state register, latch inv_q=in_inverse, set col_cnt=0, go to RUN.
- RUN:
  - The combinational column unit sees the register bytes of column col_cnt and inverse=inv_q.
  - Each cycle its 4 output bytes overwrite the same column in the register; col_cnt increments.
  - When col_cnt==3 is written: go to DONE, col_cnt wraps to 0.
  - Exactly 4 RUN cycles. in_ready=0.
- DONE:
  - out_valid=1 and out_state=the state register, held stable while out_ready=0.
  - If out_ready=1 and in_valid=0: go to IDLE.
  - If out_ready=1 and in_valid=1: the new state is accepted in the same cycle and the FSM goes straight to RUN. in_ready = out_ready in DONE.
- Latency: accept at cycle t gives out_valid at t+5. Back-to-back throughput is one state per 5 cycles.
- in_inverse is ignored except at accept. A changing in_inverse mid-RUN has no effect.
- in_valid while busy (not DONE with out_ready) is ignored; no state change.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE with the register cleared.
  - out_valid drops asynchronously.
  - The partially processed state is never emitted.
- Share hygiene: shares are never recombined. The column select mux is driven only by col_cnt (public). Unselected columns keep their register contents unchanged.

Optional Feature:
- Macro MSK_MIXCOL_SEQ_LASTROUND_EN.
- Defined:
  - Adds input port in_skip (1 bit), sampled on accept.
  - When in_skip=1, the FSM goes IDLE->DONE directly: state is loaded unmodified and out_valid is high the next cycle (latency 1). This covers the AES final round.
  - in_skip=0 behaves as baseline.
- Undefined: no in_skip port; every accepted state is processed through all 4 columns.

Decomposition:
- Shared package msk_aes_pkg:
  - FSM state encoding typedef (IDLE/RUN/DONE, 2 bits).
  - Constants N_COL=4 and BYTES_PER_COL=4.
  - Byte/column slice-offset functions parameterised by d.
- One sub-module: msk_mixcol_col_unit, the combinational 4-byte masked combined (inverse-selectable) column transform, instantiated once.
- Controller, counter, column mux and writeback remain in msk_mixcol_seq.

Test Plan:
- d=2, forward: column 0 unshared value db 13 53 45 (random share split), other columns 01 01 01 01, in_inverse=0.
  - Expected: out_valid exactly 5 cycles after accept.
  - Recombined column 0 = 8e 4d a1 bc; other columns = 01 01 01 01.
- Inverse: state with every column 8e 4d a1 bc, in_inverse=1.
  - Expected: every recombined column = db 13 53 45.
  - Forward followed by inverse on a random state returns the original.
- Backpressure: hold out_ready=0 for 7 cycles in DONE.
  - Expected: out_state bit-stable, in_ready=0.
  - Raising out_ready together with in_valid accepts the next state that same cycle, and its out_valid follows 5 cycles later.
- Reset mid-operation: assert rst_n=0 during RUN cycle 2.
  - Expected: out_valid=0, busy=0, out_state=0 immediately.
  - After release, in_ready=1 and no stale output appears.
- Direction latch: toggle in_inverse every cycle during RUN after accepting with 0.
  - Expected: result matches pure forward MixColumns.
- Optional (macro defined): in_skip=1 with a random state.
  - Expected: out_valid 1 cycle after accept, out_state bitwise equal to in_state, shares unchanged.

Source files
------------

// File: rtl/msk_aes_pkg.sv
// Shared definitions for the masked AES column datapath: FSM encoding, column geometry
// and slice-offset helpers for d-share byte sharings.
package msk_aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam int N_COL         = 4;
  localparam int BYTES_PER_COL = 4;

  // Bit offset of shared byte idx when every byte occupies 8*d bits.
  function automatic int byte_off(input int d, input int idx);
    return 8 * d * idx;
  endfunction

  // Bit offset of shared column col (BYTES_PER_COL shared bytes per column).
  function automatic int col_off(input int d, input int col);
    return 8 * d * BYTES_PER_COL * col;
  endfunction

endpackage

// File: rtl/msk_mixcol_col_unit.sv
// Masked combined MixColumns / InvMixColumns on one 4-byte column, applied share by share.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module msk_mixcol_col_unit
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                           inverse,
  input  logic [8*d*BYTES_PER_COL-1:0]   col_in,
  output logic [8*d*BYTES_PER_COL-1:0]   col_out
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar s = 0; s < d; s++) begin : g_share
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] u, v, p0, p1, p2, p3, t;

    assign a0 = col_in[byte_off(d, 0) + 8*s +: 8];
    assign a1 = col_in[byte_off(d, 1) + 8*s +: 8];
    assign a2 = col_in[byte_off(d, 2) + 8*s +: 8];
    assign a3 = col_in[byte_off(d, 3) + 8*s +: 8];

    // InvMixColumns = MixColumns after a {04}-weighted pre-mix; linear, so safe per share.
    assign u  = inverse ? xt(xt(a0 ^ a2)) : 8'h00;
    assign v  = inverse ? xt(xt(a1 ^ a3)) : 8'h00;
    assign p0 = a0 ^ u;
    assign p1 = a1 ^ v;
    assign p2 = a2 ^ u;
    assign p3 = a3 ^ v;
    assign t  = p0 ^ p1 ^ p2 ^ p3;

    assign col_out[byte_off(d, 0) + 8*s +: 8] = p0 ^ t ^ xt(p0 ^ p1);
    assign col_out[byte_off(d, 1) + 8*s +: 8] = p1 ^ t ^ xt(p1 ^ p2);
    assign col_out[byte_off(d, 2) + 8*s +: 8] = p2 ^ t ^ xt(p2 ^ p3);
    assign col_out[byte_off(d, 3) + 8*s +: 8] = p3 ^ t ^ xt(p3 ^ p0);
  end

endmodule

// File: rtl/msk_mixcol_seq.sv
// Time-shares one masked column unit over the 4 columns of a shared AES state.
// Latency: accept at t -> out_valid at t+5 (t+1 for in_skip when MSK_MIXCOL_SEQ_LASTROUND_EN).
// Backpressure: result held in DONE until out_ready; a new state is accepted in that same cycle.
module msk_mixcol_seq
  import msk_aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inverse,
`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
  input  logic             in_skip,
`endif
  input  logic [128*d-1:0] in_state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_state,
  output logic             busy
);

  localparam int COL_W = 8 * d * BYTES_PER_COL;
  localparam int CNT_W = $clog2(N_COL);

  fsm_t             st_q, st_nxt;
  logic [CNT_W-1:0] col_cnt;
  logic             inv_q;
  logic [128*d-1:0] state_q;
  logic [COL_W-1:0] col_sel, col_res;
  logic             accept, skip, step;

`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
  assign skip = in_skip;
`else
  assign skip = 1'b0;
`endif

  assign accept    = in_valid & in_ready;
  assign out_state = state_q;

  // Column select depends only on the public counter, never on share data.
  assign col_sel = state_q[col_off(d, int'(col_cnt)) +: COL_W];

  msk_mixcol_col_unit #(.d(d)) u_col (
    .inverse (inv_q),
    .col_in  (col_sel),
    .col_out (col_res)
  );

  always_comb begin
    st_nxt    = st_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    step      = 1'b0;
    case (st_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) st_nxt = skip ? DONE : RUN;
      end
      RUN: begin
        step = 1'b1;
        if (col_cnt == CNT_W'(N_COL - 1)) st_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) st_nxt = in_valid ? (skip ? DONE : RUN) : IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      inv_q   <= 1'b0;
      col_cnt <= '0;
    end else if (accept) begin
      state_q <= in_state;
      inv_q   <= in_inverse;
      col_cnt <= '0;
    end else if (step) begin
      state_q[col_off(d, int'(col_cnt)) +: COL_W] <= col_res;
      col_cnt <= col_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_msk_mixcol_seq.sv
// Scoreboard bench for msk_mixcol_seq: GF(2^8) matrix model on recombined bytes,
// random share splits, latency/backpressure/reset/direction-latch scenarios.
module tb_msk_mixcol_seq;

  localparam int D = 2;
  localparam int W = 128 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_inverse = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_state = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_state;
`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
  logic         in_skip = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  msk_mixcol_seq #(.d(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inverse (in_inverse),
`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
    .in_skip    (in_skip),
`endif
    .in_state   (in_state),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- reference model (unshared AES arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input bit inv, input int k);
    case (k)
      0: return inv ? 8'h0e : 8'h02;
      1: return inv ? 8'h0b : 8'h03;
      2: return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef(inv, (k - row + 4) % 4), s[8*(4*c+k) +: 8]);
        r[8*(4*c+row) +: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [W-1:0] share(input logic [127:0] p);
    logic [W-1:0] r;
    logic [7:0]   acc;
    for (int i = 0; i < 16; i++) begin
      acc = p[8*i +: 8];
      for (int s = 0; s < D - 1; s++) begin
        r[8*D*i + 8*s +: 8] = 8'($urandom);
        acc = acc ^ r[8*D*i + 8*s +: 8];
      end
      r[8*D*i + 8*(D-1) +: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] recomb(input logic [W-1:0] x);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      for (int s = 0; s < D; s++)
        p[8*i +: 8] = p[8*i +: 8] ^ x[8*D*i + 8*s +: 8];
    return p;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] raw;
    logic [127:0] plain;
    bit           exact;
    int           t_acc;
    int           lat;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  bit           lat_done = 1'b0;
  bit           stalled = 1'b0;
  logic [W-1:0] prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      lat_done = 1'b0;
      stalled  = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_out: got out_valid=1 want 0 (nothing pending)");
      end else begin
        if (!lat_done) begin
          chk("latency", cyc - q[0].t_acc, q[0].lat);
          lat_done = 1'b1;
        end
        if (stalled) chk("stall_hold", out_state, prev);
        if (out_ready) begin
          mon_e = q.pop_front();
          if (mon_e.exact) chk("raw_state", out_state, mon_e.raw);
          else             chk("plain_state", recomb(out_state), mon_e.plain);
          lat_done = 1'b0;
          stalled  = 1'b0;
        end else begin
          chk("stall_in_ready", in_ready, 0);
          stalled = 1'b1;
          prev    = out_state;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] st, input bit inv, input bit skip,
                      input logic [127:0] plain, input bit exact);
    exp_t e;
    int   waitc;
    waitc      = 0;
    in_valid   = 1'b1;
    in_state   = st;
    in_inverse = inv;
`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
    in_skip    = skip;
`endif
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 50 cycles");
    end else begin
      e.raw   = st;
      e.plain = plain;
      e.exact = exact;
      e.t_acc = cyc;
      e.lat   = skip ? 1 : 5;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] p, e, r, f;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_state", out_state, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known forward vector in column 0, identity-like columns elsewhere.
    for (int i = 0; i < 16; i++) begin
      p[8*i +: 8] = 8'h01;
      e[8*i +: 8] = 8'h01;
    end
    p[31:0] = 32'h4553_13db;
    e[31:0] = 32'hbca1_4d8e;
    send(share(p), 1'b0, 1'b0, e, 1'b0);
    drain();

    // Known inverse vector in every column.
    for (int c = 0; c < 4; c++) begin
      p[32*c +: 32] = 32'hbca1_4d8e;
      e[32*c +: 32] = 32'h4553_13db;
    end
    send(share(p), 1'b1, 1'b0, e, 1'b0);
    drain();

    // Random forward then inverse back-to-back: inverse returns the original.
    for (int k = 0; k < 4; k++) begin
      r = rnd128();
      f = mix(r, 1'b0);
      send(share(r), 1'b0, 1'b0, f, 1'b0);
      send(share(f), 1'b1, 1'b0, r, 1'b0);
    end
    drain();

    // Random mixed-direction traffic.
    for (int k = 0; k < 6; k++) begin
      bit inv;
      inv = 1'($urandom);
      r   = rnd128();
      send(share(r), inv, 1'b0, mix(r, inv), 1'b0);
    end
    drain();

    // Backpressure: 7 stalled DONE cycles, then release together with a new state.
    out_ready = 1'b0;
    r = rnd128();
    send(share(r), 1'b0, 1'b0, mix(r, 1'b0), 1'b0);
    repeat (11) @(posedge clk);
    #1;
    out_ready = 1'b1;
    r = rnd128();
    send(share(r), 1'b1, 1'b0, mix(r, 1'b1), 1'b0);
    drain();

    // Reset during RUN cycle 2: no partial result may ever appear.
    r = rnd128();
    send(share(r), 1'b0, 1'b0, mix(r, 1'b0), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_state", out_state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_no_output", out_valid, 0);

    // Direction is latched at accept; toggling afterwards has no effect.
    r = rnd128();
    send(share(r), 1'b0, 1'b0, mix(r, 1'b0), 1'b0);
    repeat (4) begin
      in_inverse = ~in_inverse;
      @(posedge clk);
      #1;
    end
    drain();

`ifdef MSK_MIXCOL_SEQ_LASTROUND_EN
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] sh;
      sh = share(rnd128());
      send(sh, 1'($urandom), 1'b1, recomb(sh), 1'b1);
    end
    drain();
    in_skip = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
